// File: rtl/uart_rx_deserializer.sv
// uart_rx_deserializer: 8N1 UART receiver with a two-flop synchroniser, mid-bit sampling
// and a single-entry holding register handed to DMA over a Valid/Ack handshake.
module uart_rx_deserializer #(
  parameter int FREQ_CLK    = 100_000_000,
  parameter int TX_SPEED    = 115_200,
  parameter int BIT_CYCLES  = FREQ_CLK / TX_SPEED,
  parameter int HALF_CYCLES = BIT_CYCLES / 2
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       rxd_i,
  input  logic       data_ack_i,
  output logic [7:0] data_out_o,
  output logic       data_valid_o,
  output logic       frame_err_o,
  output logic       overrun_o
);
  localparam int CW = $clog2(BIT_CYCLES);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_CYCLES - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;
  state_e        state_q, state_d;
  logic [1:0]    sync_q;
  logic          rx_s, tick;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d, data_q, data_d;
  logic          load_q, load_d, valid_q, valid_d, ferr_q, ferr_d, ovr_q, ovr_d;
  assign rx_s = sync_q[1];
  assign tick = (state_q == START) ? cnt_q == HALF_LAST : cnt_q == BIT_LAST;
  always_comb begin
    state_d = state_q;
    cnt_d   = (state_q == IDLE || tick) ? '0 : cnt_q + 1'b1;
    idx_d   = idx_q;
    shift_d = shift_q;
    load_d  = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      IDLE:  if (!rx_s) state_d = START;
      START: if (tick) begin
        state_d = rx_s ? IDLE : DATA;
        idx_d   = '0;
      end
      DATA:  if (tick) begin
        shift_d = {rx_s, shift_q[7:1]};
        if (idx_q == 3'd7) state_d = STOP;
        else idx_d = idx_q + 1'b1;
      end
      STOP:  if (tick) begin
        state_d = IDLE;
        load_d  = rx_s;
        ferr_d  = !rx_s;
      end
    endcase
    // an Ack on the load cycle consumes the old byte, so no overrun is flagged
    data_d  = load_q ? shift_q : data_q;
    valid_d = load_q | (valid_q & ~data_ack_i);
    ovr_d   = data_ack_i ? 1'b0 : ovr_q | (load_q & valid_q);
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q  <= 2'b11;
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      load_q  <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], rxd_i};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      load_q  <= load_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end
  assign data_out_o   = data_q;
  assign data_valid_o = valid_q;
  assign frame_err_o  = ferr_q;
  assign overrun_o    = ovr_q;
endmodule

// File: tb/tb_uart_rx_deserializer.sv
// tb_uart_rx_deserializer: directed and randomized 8N1 frames checked against a frame-level
// model of latency, holding register, overrun and framing-error behaviour.
module tb_uart_rx_deserializer;
  localparam int FREQ  = 3_200_000;
  localparam int SPEED = 100_000;
  localparam int BIT   = FREQ / SPEED;
  localparam int HALF  = BIT / 2;
  localparam int LAT   = 3 + HALF + 9 * BIT;
  localparam int FRAME = 10 * BIT;
  logic       clk = 1'b0, rst_n = 1'b0, rxd = 1'b1, data_ack = 1'b0;
  logic [7:0] data_out;
  logic       data_valid, frame_err, overrun;
  int checks = 0, failures = 0, cyc = 0, t0 = 0;
  int rise_cnt = 0, rise_cyc = 0, fe_cnt = 0, fe_cyc = 0, fe_hi = 0, exp_fe = 0, r = 0;
  logic       vprev = 1'b0, fprev = 1'b0;
  logic [7:0] m_data, b;
  logic       m_valid, m_ovr, stop, ack;

  uart_rx_deserializer #(.FREQ_CLK(FREQ), .TX_SPEED(SPEED)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .rxd_i(rxd), .data_ack_i(data_ack),
    .data_out_o(data_out), .data_valid_o(data_valid),
    .frame_err_o(frame_err), .overrun_o(overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (data_valid && !vprev) begin rise_cnt++; rise_cyc = cyc; end
    if (frame_err && !fprev) begin fe_cnt++; fe_cyc = cyc; end
    if (frame_err) fe_hi++;
    vprev = data_valid;
    fprev = frame_err;
  end

  initial begin
    #5ms;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic s, input int ack_at, input int rst_at);
    logic [9:0] fr;
    fr = {s, d, 1'b0};
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      if (i == 0) t0 = cyc + 1;
      rxd = fr[4'(i / BIT)];
      data_ack = (i == ack_at);
      if (i == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk("rst_async_data", 32'(data_out), 0);
        chk("rst_async_valid", 32'(data_valid), 0);
        chk("rst_async_ferr", 32'(frame_err), 0);
        chk("rst_async_ovr", 32'(overrun), 0);
      end
      if (rst_at >= 0 && i == rst_at + 5) rst_n = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rxd = 1'b1;
      data_ack = 1'b0;
    end
  endtask

  task automatic ack_pulse();
    @(negedge clk) data_ack = 1'b1;
    @(negedge clk) data_ack = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_data", 32'(data_out), 0);
    chk("reset_valid", 32'(data_valid), 0);
    chk("reset_ferr", 32'(frame_err), 0);
    chk("reset_ovr", 32'(overrun), 0);
    @(negedge clk) rst_n = 1'b1;
    idle(5);
    send(8'hAB, 1'b1, LAT + 10, -1);
    chk("ab_rise_time", rise_cyc, t0 + LAT);
    chk("ab_data", 32'(data_out), 32'hAB);
    chk("ab_valid_after_ack", 32'(data_valid), 0);
    send(8'hCD, 1'b1, LAT + 10, -1);
    chk("cd_rise_time", rise_cyc, t0 + LAT);
    chk("cd_data", 32'(data_out), 32'hCD);
    chk("cd_rise_count", rise_cnt, 2);
    chk("abcd_ferr", fe_cnt, 0);
    chk("abcd_ovr", 32'(overrun), 0);
    for (int g = 0; g < 4; g++) begin
      for (int i = 0; i < int'($urandom_range(1, HALF - 1)); i++) begin
        @(negedge clk);
        rxd = 1'b0;
      end
      idle(200);
    end
    chk("glitch_no_valid", rise_cnt, 2);
    chk("glitch_no_ferr", fe_cnt, 0);
    send(8'h55, 1'b0, -1, -1);
    idle(BIT);
    chk("badstop_ferr_count", fe_cnt, 1);
    chk("badstop_ferr_time", fe_cyc, t0 + LAT - 1);
    chk("badstop_ferr_width", fe_hi, 1);
    chk("badstop_valid", 32'(data_valid), 0);
    chk("badstop_data", 32'(data_out), 32'hCD);
    send(8'h12, 1'b1, -1, -1);
    send(8'h34, 1'b1, -1, -1);
    chk("noack_data", 32'(data_out), 32'h34);
    chk("noack_valid", 32'(data_valid), 1);
    chk("noack_ovr", 32'(overrun), 1);
    ack_pulse();
    chk("ack_clears_valid", 32'(data_valid), 0);
    chk("ack_clears_ovr", 32'(overrun), 0);
    send(8'h12, 1'b1, -1, -1);
    send(8'h34, 1'b1, LAT, -1);
    chk("ackload_data", 32'(data_out), 32'h34);
    chk("ackload_valid", 32'(data_valid), 1);
    chk("ackload_ovr", 32'(overrun), 0);
    ack_pulse();
    send(8'h66, 1'b1, -1, -1);
    send(8'h77, 1'b1, -1, -1);
    chk("prerst_ovr", 32'(overrun), 1);
    r = rise_cnt;
    send(8'hF0, 1'b1, -1, 5 * BIT + HALF);
    idle(BIT);
    chk("rst_partial_no_valid", rise_cnt, r);
    chk("rst_partial_valid", 32'(data_valid), 0);
    send(8'hA5, 1'b1, -1, -1);
    chk("postrst_data", 32'(data_out), 32'hA5);
    chk("postrst_valid", 32'(data_valid), 1);
    chk("postrst_rise_count", rise_cnt, r + 1);
    chk("postrst_ovr", 32'(overrun), 0);
    ack_pulse();
    m_data = 8'hA5;
    m_valid = 1'b0;
    m_ovr = 1'b0;
    exp_fe = fe_cnt;
    for (int n = 0; n < 16; n++) begin
      b = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      ack = 1'($urandom_range(0, 1));
      send(b, stop, ack ? LAT + 1 + int'($urandom_range(0, 8)) : -1, -1);
      if (stop) idle(int'($urandom_range(0, 20)));
      else idle(BIT + int'($urandom_range(0, 20)));
      if (stop) begin
        m_ovr = m_ovr | m_valid;
        m_valid = 1'b1;
        m_data = b;
      end else exp_fe++;
      if (ack) begin
        m_valid = 1'b0;
        m_ovr = 1'b0;
      end
      chk("rand_data", 32'(data_out), 32'(m_data));
      chk("rand_valid", 32'(data_valid), 32'(m_valid));
      chk("rand_ovr", 32'(overrun), 32'(m_ovr));
      chk("rand_ferr_count", fe_cnt, exp_fe);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
